// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared widths, hold encodings and FSM states for pipe_ctrl
// Contents:
//   INST_ADDR_W / HOLD_W   : instruction address and hold-flag bus widths
//   HOLD_*                 : hold levels, numerically ordered None < Pc < If < Id
//   RST_ENABLE             : reset level (active-low)
//   CPU_RESET_ADDR         : jump address after reset
//   pctrl_state_e          : pipe_ctrl FSM states
//   hold_max()             : numeric maximum of two hold levels
package pipe_ctrl_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int HOLD_W      = 3;

  localparam logic [HOLD_W-1:0] HOLD_NONE = 3'd0;
  localparam logic [HOLD_W-1:0] HOLD_PC   = 3'd1;
  localparam logic [HOLD_W-1:0] HOLD_IF   = 3'd2;
  localparam logic [HOLD_W-1:0] HOLD_ID   = 3'd3;

  localparam logic RST_ENABLE  = 1'b0;
  localparam logic JUMP_ENABLE = 1'b1;

  localparam logic [INST_ADDR_W-1:0] CPU_RESET_ADDR = 32'h0000_0000;

  typedef enum logic [1:0] {
    PCTRL_RUN  = 2'd0,
    PCTRL_HOLD = 2'd1,
    PCTRL_INT  = 2'd2
  } pctrl_state_e;

  // Higher encoding means a deeper stall, so the merge is a plain maximum.
  function automatic logic [HOLD_W-1:0] hold_max(input logic [HOLD_W-1:0] a,
                                                  input logic [HOLD_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipe_ctrl_int_latch.sv
// rtl/pipe_ctrl_int_latch.sv - captures one pending interrupt and its vector
// Ports:
//   clk, rst     : clock, synchronous active-low reset
//   int_req_i    : interrupt request pulse
//   int_addr_i   : interrupt vector, valid with int_req_i
//   int_clr_i    : clears the pending interrupt once its jump is issued
//   int_pend_o   : an interrupt is waiting to be issued
//   int_vec_o    : vector of the waiting interrupt
module pipe_ctrl_int_latch
  import pipe_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   int_req_i,
  input  logic [INST_ADDR_W-1:0] int_addr_i,
  input  logic                   int_clr_i,
  output logic                   int_pend_o,
  output logic [INST_ADDR_W-1:0] int_vec_o
);

  logic                   int_pend_q, int_pend_d;
  logic [INST_ADDR_W-1:0] int_vec_q, int_vec_d;

  // While an interrupt is pending further requests are dropped so the first
  // vector is the one that gets serviced.
  always_comb begin
    int_pend_d = int_pend_q;
    int_vec_d  = int_vec_q;
    if (int_clr_i) begin
      int_pend_d = 1'b0;
    end else if (int_req_i && !int_pend_q) begin
      int_pend_d = 1'b1;
      int_vec_d  = int_addr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      int_pend_q <= 1'b0;
      int_vec_q  <= CPU_RESET_ADDR;
    end else begin
      int_pend_q <= int_pend_d;
      int_vec_q  <= int_vec_d;
    end
  end

  assign int_pend_o = int_pend_q;
  assign int_vec_o  = int_vec_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - merges jump, hold and interrupt requests into one registered pipeline command
// Ports:
//   clk, rst       : clock, synchronous active-low reset
//   jump_flag_i    : ex requests a jump this cycle
//   jump_addr_i    : ex jump target
//   hold_ex_i      : ex hold request (multi-cycle ops)
//   hold_rib_i     : bus arbiter busy
//   jtag_halt_i    : debugger halt (level)
//   int_req_i      : interrupt request pulse
//   int_addr_i     : interrupt vector, valid with int_req_i
//   jump_flag_o    : one-cycle jump command to pc_reg / stage registers
//   jump_addr_o    : jump target, holds last value when idle
//   hold_flag_o    : hold level to pc_reg / stage registers
//   int_ack_o      : pulse when the interrupt jump is issued
//   bus_timeout_o  : sticky flag, bus held for BUS_TO_CYCLES consecutive cycles
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BUS_TO_CYCLES = 16,
  parameter int TO_CNT_W      = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   jump_flag_i,
  input  logic [INST_ADDR_W-1:0] jump_addr_i,
  input  logic [HOLD_W-1:0]      hold_ex_i,
  input  logic                   hold_rib_i,
  input  logic                   jtag_halt_i,
  input  logic                   int_req_i,
  input  logic [INST_ADDR_W-1:0] int_addr_i,
  output logic                   jump_flag_o,
  output logic [INST_ADDR_W-1:0] jump_addr_o,
  output logic [HOLD_W-1:0]      hold_flag_o,
  output logic                   int_ack_o,
  output logic                   bus_timeout_o
);

  localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(BUS_TO_CYCLES);

  pctrl_state_e state_q, state_d;

  logic                   jump_q, jump_d;
  logic [INST_ADDR_W-1:0] jump_addr_q, jump_addr_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   ack_q, ack_d;
  logic [TO_CNT_W-1:0]    to_cnt_q, to_cnt_d;
  logic                   timeout_q, timeout_d;

  logic                   int_pend;
  logic [INST_ADDR_W-1:0] int_vec;
  logic                   int_clr;
  logic [HOLD_W-1:0]      hold_req;
  logic                   jump_req;

  assign jump_req = (jump_flag_i == JUMP_ENABLE);
  assign hold_req = hold_max(hold_ex_i,
                             hold_max(hold_rib_i  ? HOLD_PC : HOLD_NONE,
                                      jtag_halt_i ? HOLD_PC : HOLD_NONE));

  pipe_ctrl_int_latch u_int_latch (
    .clk        (clk),
    .rst        (rst),
    .int_req_i  (int_req_i),
    .int_addr_i (int_addr_i),
    .int_clr_i  (int_clr),
    .int_pend_o (int_pend),
    .int_vec_o  (int_vec)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= PCTRL_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = PCTRL_RUN;
    case (state_q)
      PCTRL_RUN: begin
        if (jump_req)                  state_d = PCTRL_RUN;
        else if (hold_req != HOLD_NONE) state_d = PCTRL_HOLD;
        else if (int_pend)             state_d = PCTRL_INT;
        else                           state_d = PCTRL_RUN;
      end
      PCTRL_HOLD: begin
        state_d = (hold_req != HOLD_NONE) ? PCTRL_HOLD : PCTRL_RUN;
      end
      PCTRL_INT: begin
        // An ex jump or a debug halt in the entry cycle defers the interrupt;
        // int_pend stays set so RUN retries it once things are quiet.
        if (jump_req)         state_d = PCTRL_RUN;
        else if (jtag_halt_i) state_d = PCTRL_HOLD;
        else                  state_d = PCTRL_RUN;
      end
      default: state_d = PCTRL_RUN;
    endcase
  end

  // Output logic (registered below)
  always_comb begin
    jump_d      = 1'b0;
    jump_addr_d = jump_addr_q;
    hold_d      = HOLD_NONE;
    ack_d       = 1'b0;
    int_clr     = 1'b0;
    case (state_q)
      PCTRL_RUN: begin
        if (jump_req) begin
          jump_d      = 1'b1;
          jump_addr_d = jump_addr_i;
        end else if (hold_req != HOLD_NONE) begin
          hold_d = hold_req;
        end
      end
      PCTRL_HOLD: begin
        // The stall keeps applying; a jump from ex is still honoured so a
        // resolved branch is never lost while the pipeline is frozen.
        hold_d = hold_req;
        if (jump_req) begin
          jump_d      = 1'b1;
          jump_addr_d = jump_addr_i;
        end
      end
      PCTRL_INT: begin
        if (jump_req) begin
          jump_d      = 1'b1;
          jump_addr_d = jump_addr_i;
        end else if (jtag_halt_i) begin
          hold_d = hold_req;
        end else begin
          // Flush IF/ID and ID/EX so nothing behind the interrupt retires.
          jump_d      = 1'b1;
          jump_addr_d = int_vec;
          hold_d      = HOLD_ID;
          ack_d       = 1'b1;
          int_clr     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Bus-hold watchdog: saturates at the limit so the compare stays true.
  always_comb begin
    to_cnt_d = '0;
    if (hold_rib_i) begin
      to_cnt_d = (to_cnt_q == TO_LIMIT) ? to_cnt_q : to_cnt_q + 1'b1;
    end
    timeout_d = timeout_q | (to_cnt_d == TO_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      jump_q      <= 1'b0;
      jump_addr_q <= CPU_RESET_ADDR;
      hold_q      <= HOLD_NONE;
      ack_q       <= 1'b0;
      to_cnt_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      jump_q      <= jump_d;
      jump_addr_q <= jump_addr_d;
      hold_q      <= hold_d;
      ack_q       <= ack_d;
      to_cnt_q    <= to_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign jump_flag_o   = jump_q;
  assign jump_addr_o   = jump_addr_q;
  assign hold_flag_o   = hold_q;
  assign int_ack_o     = ack_q;
  assign bus_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic [2:0]  hold_ex_i;
  logic        hold_rib_i;
  logic        jtag_halt_i;
  logic        int_req_i;
  logic [31:0] int_addr_i;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic [2:0]  hold_flag_o;
  logic        int_ack_o;
  logic        bus_timeout_o;

  always #5 clk = ~clk;

  pipe_ctrl #(.BUS_TO_CYCLES(16), .TO_CNT_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .jump_flag_i   (jump_flag_i),
    .jump_addr_i   (jump_addr_i),
    .hold_ex_i     (hold_ex_i),
    .hold_rib_i    (hold_rib_i),
    .jtag_halt_i   (jtag_halt_i),
    .int_req_i     (int_req_i),
    .int_addr_i    (int_addr_i),
    .jump_flag_o   (jump_flag_o),
    .jump_addr_o   (jump_addr_o),
    .hold_flag_o   (hold_flag_o),
    .int_ack_o     (int_ack_o),
    .bus_timeout_o (bus_timeout_o)
  );

  typedef struct packed {
    logic        jf;
    logic [31:0] ja;
    logic [2:0]  hold;
    logic        ack;
    logic        to;
  } exp_t;

  typedef struct {
    logic        jf;
    logic [31:0] ja;
    logic [2:0]  hx;
    logic        rib;
    logic        halt;
    logic        irq;
    logic [31:0] ia;
    exp_t        e;
  } vec_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  vec_t tbl[35];

  function automatic exp_t ex(input logic jf, input logic [31:0] ja,
                              input logic [2:0] hold, input logic ack,
                              input logic to);
    exp_t e;
    e.jf = jf; e.ja = ja; e.hold = hold; e.ack = ack; e.to = to;
    return e;
  endfunction

  function automatic vec_t v(input logic jf, input logic [31:0] ja,
                             input logic [2:0] hx, input logic rib,
                             input logic halt, input logic irq,
                             input logic [31:0] ia, input exp_t e);
    vec_t r;
    r.jf = jf; r.ja = ja; r.hx = hx; r.rib = rib; r.halt = halt;
    r.irq = irq; r.ia = ia; r.e = e;
    return r;
  endfunction

  task automatic check(input string name);
    exp_t want, got;
    n_total++;
    got = {jump_flag_o, jump_addr_o, hold_flag_o, int_ack_o, bus_timeout_o};
    if (sb_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty, got jf=%0b addr=%h hold=%0d ack=%0b to=%0b",
               name, got.jf, got.ja, got.hold, got.ack, got.to);
    end else begin
      want = sb_q.pop_front();
      if (got === want) n_pass++;
      else
        $display("FAIL %s: got jf=%0b addr=%h hold=%0d ack=%0b to=%0b, want jf=%0b addr=%h hold=%0d ack=%0b to=%0b",
                 name, got.jf, got.ja, got.hold, got.ack, got.to,
                 want.jf, want.ja, want.hold, want.ack, want.to);
    end
  endtask

  task automatic step(input logic r, input vec_t x, input string name);
    rst         = r;
    jump_flag_i = x.jf;
    jump_addr_i = x.ja;
    hold_ex_i   = x.hx;
    hold_rib_i  = x.rib;
    jtag_halt_i = x.halt;
    int_req_i   = x.irq;
    int_addr_i  = x.ia;
    sb_q.push_back(x.e);
    @(posedge clk);
    #1;
    check(name);
  endtask

  initial begin
    exp_t z;
    z = ex(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0; jump_flag_i = 1'b0; jump_addr_i = '0; hold_ex_i = '0;
    hold_rib_i = 1'b0; jtag_halt_i = 1'b0; int_req_i = 1'b0; int_addr_i = '0;

    // Inputs for a cycle, and the outputs expected right after that edge.
    tbl[0]  = v(0, 32'h0,   0, 0, 0, 0, 32'h0,   ex(0, 32'h0,   0, 0, 0));
    tbl[1]  = v(0, 32'h0,   0, 0, 0, 0, 32'h0,   ex(0, 32'h0,   0, 0, 0));
    tbl[2]  = v(1, 32'h100, 0, 0, 0, 0, 32'h0,   ex(1, 32'h100, 0, 0, 0));
    tbl[3]  = v(0, 32'h0,   0, 0, 0, 0, 32'h0,   ex(0, 32'h100, 0, 0, 0));
    tbl[4]  = v(0, 32'h0,   3, 1, 0, 0, 32'h0,   ex(0, 32'h100, 3, 0, 0));
    tbl[5]  = v(0, 32'h0,   3, 1, 0, 0, 32'h0,   ex(0, 32'h100, 3, 0, 0));
    tbl[6]  = v(0, 32'h0,   3, 1, 0, 0, 32'h0,   ex(0, 32'h100, 3, 0, 0));
    tbl[7]  = v(0, 32'h0,   0, 0, 0, 0, 32'h0,   ex(0, 32'h100, 0, 0, 0));
    tbl[8]  = v(0, 32'h0,   2, 0, 0, 1, 32'h800, ex(0, 32'h100, 2, 0, 0));
    tbl[9]  = v(0, 32'h0,   2, 0, 0, 0, 32'h0,   ex(0, 32'h100, 2, 0, 0));
    tbl[10] = v(0, 32'h0,   2, 0, 0, 0, 32'h0,   ex(0, 32'h100, 2, 0, 0));
    tbl[11] = v(0, 32'h0,   2, 0, 0, 0, 32'h0,   ex(0, 32'h100, 2, 0, 0));
    tbl[12] = v(0, 32'h0,   0, 0, 0, 0, 32'h0,   ex(0, 32'h100, 0, 0, 0));
    tbl[13] = v(0, 32'h0,   0, 0, 0, 0, 32'h0,   ex(0, 32'h100, 0, 0, 0));
    tbl[14] = v(0, 32'h0,   0, 0, 0, 0, 32'h0,   ex(1, 32'h800, 3, 1, 0));
    tbl[15] = v(0, 32'h0,   0, 0, 0, 0, 32'h0,   ex(0, 32'h800, 0, 0, 0));
    tbl[16] = v(1, 32'h40,  0, 0, 0, 1, 32'h900, ex(1, 32'h40,  0, 0, 0));
    tbl[17] = v(0, 32'h0,   0, 0, 0, 0, 32'h0,   ex(0, 32'h40,  0, 0, 0));
    tbl[18] = v(0, 32'h0,   0, 0, 0, 0, 32'h0,   ex(1, 32'h900, 3, 1, 0));
    tbl[19] = v(0, 32'h0,   0, 0, 0, 0, 32'h0,   ex(0, 32'h900, 0, 0, 0));
    tbl[20] = v(0, 32'h0,   0, 0, 0, 1, 32'hA00, ex(0, 32'h900, 0, 0, 0));
    tbl[21] = v(0, 32'h0,   0, 0, 0, 1, 32'hB00, ex(0, 32'h900, 0, 0, 0));
    tbl[22] = v(1, 32'h200, 0, 0, 0, 0, 32'h0,   ex(1, 32'h200, 0, 0, 0));
    tbl[23] = v(0, 32'h0,   0, 0, 0, 0, 32'h0,   ex(0, 32'h200, 0, 0, 0));
    tbl[24] = v(0, 32'h0,   0, 0, 1, 0, 32'h0,   ex(0, 32'h200, 1, 0, 0));
    tbl[25] = v(0, 32'h0,   0, 0, 1, 0, 32'h0,   ex(0, 32'h200, 1, 0, 0));
    tbl[26] = v(0, 32'h0,   0, 0, 0, 0, 32'h0,   ex(0, 32'h200, 0, 0, 0));
    tbl[27] = v(0, 32'h0,   0, 0, 0, 0, 32'h0,   ex(0, 32'h200, 0, 0, 0));
    tbl[28] = v(0, 32'h0,   0, 0, 0, 0, 32'h0,   ex(1, 32'hA00, 3, 1, 0));
    tbl[29] = v(0, 32'h0,   2, 0, 0, 0, 32'h0,   ex(0, 32'hA00, 2, 0, 0));
    tbl[30] = v(1, 32'h300, 2, 0, 0, 0, 32'h0,   ex(1, 32'h300, 2, 0, 0));
    tbl[31] = v(0, 32'h0,   0, 0, 0, 0, 32'h0,   ex(0, 32'h300, 0, 0, 0));
    tbl[32] = v(0, 32'h0,   0, 1, 0, 0, 32'h0,   ex(0, 32'h300, 1, 0, 0));
    tbl[33] = v(0, 32'h0,   2, 1, 1, 0, 32'h0,   ex(0, 32'h300, 2, 0, 0));
    tbl[34] = v(0, 32'h0,   0, 0, 0, 0, 32'h0,   ex(0, 32'h300, 0, 0, 0));

    for (int i = 0; i < 2; i++) step(1'b0, v(0, 0, 0, 0, 0, 0, 0, z), "reset");

    for (int i = 0; i < 35; i++) step(1'b1, tbl[i], $sformatf("vec%0d", i));

    // Bus held for 20 cycles: flag appears after the 16th held cycle.
    for (int k = 0; k < 20; k++)
      step(1'b1, v(0, 0, 0, 1, 0, 0, 0, ex(0, 32'h300, 1, 0, (k >= 15))),
           $sformatf("bus_hold%0d", k));
    for (int k = 0; k < 3; k++)
      step(1'b1, v(0, 0, 0, 0, 0, 0, 0, ex(0, 32'h300, 0, 0, 1)),
           $sformatf("timeout_sticky%0d", k));

    // Interrupt latched, then reset before it is issued: it must be lost.
    step(1'b1, v(0, 0, 0, 0, 0, 1, 32'hC00, ex(0, 32'h300, 0, 0, 1)), "irq_before_reset");
    for (int k = 0; k < 2; k++) step(1'b0, v(0, 0, 0, 0, 0, 0, 0, z), "mid_int_reset");
    for (int k = 0; k < 3; k++)
      step(1'b1, v(0, 0, 0, 0, 0, 0, 0, z), $sformatf("post_reset_idle%0d", k));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit that drives the PC register and the IF/ID and ID/EX stage registers.
- Merges the following into one registered jump/hold command per cycle: execute-stage jump requests, hold requests (execute multi-cycle ops, bus arbiter, debug halt) and interrupt entry requests.
- Latches and queues an interrupt until the pipeline is quiet, then issues it as a jump.
- Sits between ex/rib/clint/jtag and pc_reg plus the stage registers.

Parameters:
BUS_TO_CYCLES, 16, consecutive bus-hold cycles after which bus_timeout_o is raised
TO_CNT_W, 5, width of bus-hold counter (must hold BUS_TO_CYCLES)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-low (`RstEnable == 1'b0)
jump_flag_i  input  1  ex requests jump this cycle
jump_addr_i  input  `InstAddrBus  ex jump target
hold_ex_i  input  `Hold_Flag_Bus  ex hold request (multi-cycle div/mul)
hold_rib_i  input  1  bus arbiter busy, stall fetch
jtag_halt_i  input  1  debugger halt, level
int_req_i  input  1  interrupt request pulse from clint
int_addr_i  input  `InstAddrBus  interrupt vector, valid with int_req_i
jump_flag_o  output  1  to pc_reg / stage regs
jump_addr_o  output  `InstAddrBus  to pc_reg
hold_flag_o  output  `Hold_Flag_Bus  to pc_reg / stage regs
int_ack_o  output  1  one-cycle pulse when interrupt jump issued
bus_timeout_o  output  1  sticky bus-hold timeout flag

Behaviour:
- All outputs registered; decision made from cycle-N inputs appears on outputs in cycle N+1.
- Reset (rst==0 at posedge), including mid-interrupt: jump_flag_o=0, jump_addr_o=`CpuResetAddr, hold_flag_o=`Hold_None, int_ack_o=0, bus_timeout_o=0, int_pend=0, counter=0, state=RUN.
- Hold merge: req = max(hold_ex_i, hold_rib_i ? `Hold_Pc : `Hold_None, jtag_halt_i ? `Hold_Pc : `Hold_None). Compare numerically: None=0 < Pc=1 < If=2 < Id=3.
- Interrupt latch: int_req_i sets int_pend and captures int_addr_i into int_vec.
  - A new request while int_pend=1 is ignored; the first vector is kept.
- States:
  - RUN:
    - If jump_flag_i: jump_flag_o=1, jump_addr_o=jump_addr_i, hold_flag_o=`Hold_None. Stay in RUN.
    - Else if req != None: hold_flag_o=req, go to HOLD.
    - Else if int_pend: go to INT_JUMP, outputs idle this cycle.
    - Else: all outputs idle.
  - HOLD:
    - hold_flag_o=req while req != None.
    - A jump_flag_i still wins: jump issued with hold_flag_o=req.
    - When req==None: return to RUN, outputs idle.
  - INT_JUMP (one cycle):
    - jump_flag_o=1, jump_addr_o=int_vec, hold_flag_o=`Hold_Id, int_ack_o=1. Clear int_pend, go to RUN.
    - If jump_flag_i arrives in the cycle of the transition into INT_JUMP, the ex jump has priority. The interrupt is deferred with int_pend retained and state RUN.
    - jtag_halt_i asserted in INT_JUMP's entry cycle also defers the interrupt.
- jump_flag_o is high for exactly one cycle per accepted jump. jump_addr_o holds its last value when jump_flag_o=0.
- Bus timeout counter:
  - Increments, saturating, while hold_rib_i=1; clears when hold_rib_i=0.
  - When it reaches BUS_TO_CYCLES, bus_timeout_o is set and stays set until reset.
- A simultaneous int_req_i and jump_flag_i are both honoured: the jump is issued now and the interrupt is latched for later.

Decomposition:
- Shared defines: `InstAddrBus, `Hold_Flag_Bus, `Hold_None/`Hold_Pc/`Hold_If/`Hold_Id, `RstEnable, `CpuResetAddr, `JumpEnable, plus new state encodings PCTRL_RUN/PCTRL_HOLD/PCTRL_INT.
- One sub-module: pipe_ctrl_int_latch (int_pend/int_vec capture and clear).

Test Plan:
- Reset for 2 cycles with rst=0, then release -> hold_flag_o=0, jump_flag_o=0, jump_addr_o=0x00000000; all outputs stay idle with no requests.
- jump_flag_i=1, jump_addr_i=0x00000100 for one cycle -> next cycle jump_flag_o=1 with addr 0x100; the cycle after, jump_flag_o=0 and addr still 0x100.
- hold_ex_i=`Hold_Id for 3 cycles together with hold_rib_i=1 -> hold_flag_o=3 for 3 cycles, then 0 one cycle after release.
- int_req_i pulse with int_addr_i=0x00000800 while hold_ex_i=`Hold_If for 4 cycles -> no ack during the hold. After release, one cycle of jump_flag_o=1 / addr 0x800 / hold=3 / int_ack_o=1.
- int_req_i and jump_flag_i (addr 0x40) in the same cycle -> jump to 0x40 issued first; the interrupt jump to its vector follows 2 cycles later.
- hold_rib_i=1 for 20 cycles -> bus_timeout_o rises after the 16th cycle, stays 1 after hold_rib_i drops, and clears only on rst=0.
